// File: rtl/imem_loadable_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable_if
//  Description : Bus bundle for the loadable instruction memory: program
//                load stream, load status and the fetch port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loadable_if #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
);
    // Program load path
    logic                   load_en;
    logic                   load_valid;
    logic [INS_W-1:0]       load_data;
    logic                   load_full;
    logic [INS_ADDRESS-2:0] load_count;

    // Fetch path
    logic [INS_ADDRESS-1:0] ra;
    logic                   stall;
    logic [INS_W-1:0]       rd;
    logic                   rd_valid;
    logic                   misaligned;

    // Boot/programming path plus fetch stage side
    modport master (
        output load_en, load_valid, load_data, ra, stall,
        input  load_full, load_count, rd, rd_valid, misaligned
    );

    // Memory side
    modport slave (
        input  load_en, load_valid, load_data, ra, stall,
        output load_full, load_count, rd, rd_valid, misaligned
    );
endinterface
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loadable
//  Description : Instruction memory that is programmed by a word stream in
//                LOAD mode and serves registered 1-cycle fetches in RUN mode.
//                Words not written in the current session read as NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loadable #(
    parameter int               INS_ADDRESS = 9,
    parameter int               INS_W       = 32,
    parameter logic [INS_W-1:0] NOP_WORD    = 32'h00000013
) (
    input  wire logic         clk,
    input  wire logic         reset,
    imem_loadable_if.slave    bus
);

    localparam int                   C_IDX_W   = INS_ADDRESS - 2;
    localparam int                   C_CNT_W   = INS_ADDRESS - 1;
    localparam int                   C_DEPTH_N = 2 ** C_IDX_W;
    localparam logic [C_CNT_W-1:0]   C_DEPTH   = C_CNT_W'(C_DEPTH_N);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_enter_load;
    logic                 w_wr_en;
    logic                 w_full;

    logic [C_CNT_W-1:0]   r_count;
    logic [C_DEPTH_N-1:0] r_flag;
    logic [INS_W-1:0]     r_mem [C_DEPTH_N];

    logic [INS_W-1:0]     r_rd;
    logic                 r_rd_valid;
    logic                 r_misaligned;

    // The write pointer always equals the low bits of the word count; once
    // the count saturates at DEPTH no further writes happen, so the pointer
    // never wraps onto a written word.
    logic [C_IDX_W-1:0]   w_ptr;
    logic [C_IDX_W-1:0]   w_idx;

    assign w_ptr  = r_count[C_IDX_W-1:0];
    assign w_idx  = bus.ra[INS_ADDRESS-1:2];
    assign w_full = (r_count == C_DEPTH);

    // Mode register; reset always returns to LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus write enable and session-restart strobe
    always_comb begin
        w_state_nxt  = r_state;
        w_enter_load = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                // A word offered on the LOAD->RUN edge is still taken,
                // since the decision uses the pre-edge state.
                w_wr_en = bus.load_valid && !w_full;
                if (!bus.load_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.load_en) begin
                    w_state_nxt  = ST_LOAD;
                    w_enter_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Session word counter and written-flag vector
    always_ff @(posedge clk) begin
        if (reset || w_enter_load) begin
            r_count <= '0;
            r_flag  <= '0;
        end else if (w_wr_en) begin
            r_count        <= r_count + 1'b1;
            r_flag[w_ptr]  <= 1'b1;
        end
    end

    // Storage array; contents are never cleared, the flags mask stale data
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_ptr] <= bus.load_data;
        end
    end

    // Registered fetch port; holds on stall, parks at NOP while loading
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_LOAD)) begin
            r_rd         <= NOP_WORD;
            r_rd_valid   <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!bus.stall) begin
            r_rd         <= r_flag[w_idx] ? r_mem[w_idx] : NOP_WORD;
            r_rd_valid   <= 1'b1;
            r_misaligned <= |bus.ra[1:0];
        end
    end

    assign bus.load_full  = w_full;
    assign bus.load_count = r_count;
    assign bus.rd         = r_rd;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loadable
//  Description : Self-checking bench for imem_loadable: load sessions, fetch
//                vectors, stall hold, misalignment, reset and mode changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loadable;

    localparam int          INS_ADDRESS = 9;
    localparam int          INS_W       = 32;
    localparam logic [31:0] NOP         = 32'h00000013;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    imem_loadable_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();

    imem_loadable #(
        .INS_ADDRESS (INS_ADDRESS),
        .INS_W       (INS_W),
        .NOP_WORD    (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        valid;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [8:0]  ra;
        logic [31:0] rd;
        logic        mis;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    logic [31:0] prog[4];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one fetch, queue its expectation, then compare after the edge
    task automatic fetch(input string name, input logic [8:0] ra,
                         input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        exp_t g;
        bus.ra    = ra;
        bus.stall = 1'b0;
        e.rd = exp_rd; e.valid = 1'b1; e.mis = exp_mis;
        sb.push_back(e);
        tick();
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            g = sb.pop_front();
            check({name, "_rd"},  bus.rd, g.rd);
            check({name, "_vld"}, 32'(bus.rd_valid), 32'(g.valid));
            check({name, "_mis"}, 32'(bus.misaligned), 32'(g.mis));
        end
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus and checking
    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000073;

        vecs[0] = '{ra: 9'h000, rd: prog[0], mis: 1'b0};
        vecs[1] = '{ra: 9'h004, rd: prog[1], mis: 1'b0};
        vecs[2] = '{ra: 9'h008, rd: prog[2], mis: 1'b0};
        vecs[3] = '{ra: 9'h00C, rd: prog[3], mis: 1'b0};
        vecs[4] = '{ra: 9'h010, rd: NOP,     mis: 1'b0};
        vecs[5] = '{ra: 9'h1FC, rd: NOP,     mis: 1'b0};
        vecs[6] = '{ra: 9'h006, rd: prog[1], mis: 1'b1};
        vecs[7] = '{ra: 9'h008, rd: prog[2], mis: 1'b0};

        reset          = 1'b1;
        bus.load_en    = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.ra         = '0;
        bus.stall      = 1'b0;
        tick();
        tick();
        check("rst_rd",    bus.rd, NOP);
        check("rst_vld",   32'(bus.rd_valid), 32'd0);
        check("rst_mis",   32'(bus.misaligned), 32'd0);
        check("rst_full",  32'(bus.load_full), 32'd0);
        check("rst_count", 32'(bus.load_count), 32'd0);

        // Four-word program load
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            tick();
        end
        bus.load_valid = 1'b0;
        check("ld4_count", 32'(bus.load_count), 32'd4);
        check("ld4_full",  32'(bus.load_full), 32'd0);
        check("ld4_vld",   32'(bus.rd_valid), 32'd0);

        // LOAD->RUN: no valid output right after the switching edge
        bus.load_en = 1'b0;
        tick();
        check("run_edge_vld", 32'(bus.rd_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].ra, vecs[i].rd, vecs[i].mis);
        end

        // Stall hold: word 1 stays while ra moves underneath
        fetch("pre_stall", 9'h004, prog[1], 1'b0);
        bus.stall = 1'b1;
        bus.ra    = 9'h008;
        tick();
        check("stall1_rd",  bus.rd, prog[1]);
        check("stall1_vld", 32'(bus.rd_valid), 32'd1);
        bus.ra = 9'h00E;
        tick();
        check("stall2_rd",  bus.rd, prog[1]);
        check("stall2_mis", 32'(bus.misaligned), 32'd0);
        fetch("post_stall", 9'h008, prog[2], 1'b0);

        // Full 128-word load plus three extra words
        bus.load_en = 1'b1;
        tick();
        check("r2l_edge_vld", 32'(bus.rd_valid), 32'd1);
        check("r2l_count",    32'(bus.load_count), 32'd0);
        for (int i = 0; i < 131; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
        check("full_count", 32'(bus.load_count), 32'd128);
        check("full_flag",  32'(bus.load_full), 32'd1);
        check("load_rd",    bus.rd, NOP);
        check("load_vld",   32'(bus.rd_valid), 32'd0);
        bus.load_en = 1'b0;
        tick();
        fetch("full_1fc", 9'h1FC, 32'h0000007F, 1'b0);
        fetch("full_010", 9'h010, 32'h00000004, 1'b0);
        fetch("full_000", 9'h000, 32'h00000000, 1'b0);
        check("run_full",  32'(bus.load_full), 32'd1);
        check("run_count", 32'(bus.load_count), 32'd128);

        // Reset in the middle of a ten-word session
        bus.load_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hA0 + 32'(i);
            tick();
        end
        check("mid_count", 32'(bus.load_count), 32'd5);
        reset = 1'b1;
        tick();
        check("mrst_count", 32'(bus.load_count), 32'd0);
        check("mrst_vld",   32'(bus.rd_valid), 32'd0);
        check("mrst_full",  32'(bus.load_full), 32'd0);
        reset          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_en    = 1'b0;
        tick();
        fetch("mrst_000", 9'h000, NOP, 1'b0);
        fetch("mrst_004", 9'h004, NOP, 1'b0);
        fetch("mrst_1fc", 9'h1FC, NOP, 1'b0);

        // Word offered on the LOAD->RUN edge is kept; RUN-mode valid ignored
        bus.load_en = 1'b1;
        tick();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEADBEEF;
        tick();
        bus.load_data  = 32'hCAFE0001;
        bus.load_en    = 1'b0;
        tick();
        bus.load_data  = 32'h12345678;
        tick();
        bus.load_valid = 1'b0;
        check("edge_count", 32'(bus.load_count), 32'd2);
        fetch("edge_000", 9'h000, 32'hDEADBEEF, 1'b0);
        fetch("edge_004", 9'h004, 32'hCAFE0001, 1'b0);
        fetch("edge_008", 9'h008, NOP, 1'b0);

        // RUN->LOAD->RUN with no writes masks the previous program
        bus.load_en = 1'b1;
        tick();
        bus.load_en = 1'b0;
        tick();
        check("empty_count", 32'(bus.load_count), 32'd0);
        check("empty_vld",   32'(bus.rd_valid), 32'd0);
        fetch("empty_000", 9'h000, NOP, 1'b0);
        fetch("empty_004", 9'h004, NOP, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
